// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-stream 1-to-4 demultiplexer.
package axis_pkg;

  localparam int AXIS_NPORTS = 4;
  localparam int AXIS_SEL_W  = $clog2(AXIS_NPORTS);
  localparam int AXIS_DATA_W = 16;

  typedef logic [AXIS_SEL_W-1:0] axis_sel_t;

  typedef enum logic {
    IDLE,
    BUSY
  } axis_demux_state_e;

  // Beat as held in the output stage at the default data width.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic                   last;
    axis_sel_t              dst;
  } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// One-entry skid buffer behind a registered output stage; the upstream ready
// is itself a register, so no combinational path runs from out_ready to in_ready.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_payload,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_payload,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_q;
  logic         skid_full;
  logic         skid_full_next;
  logic         accept;
  logic         drain;
  logic         load_out;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    accept         = in_valid && in_ready;
    drain          = out_valid && out_ready;
    load_out       = !out_valid || drain;
    skid_full_next = skid_full ? !drain : (accept && !load_out);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_payload <= '0;
      out_valid   <= 1'b0;
      skid_q      <= '0;
      skid_full   <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      if (skid_full) begin
        // in_ready is low while the skid is full, so only the drain can happen.
        if (drain) begin
          out_payload <= skid_q;
          skid_full   <= 1'b0;
        end
      end else if (accept) begin
        if (load_out) begin
          out_payload <= in_payload;
          out_valid   <= 1'b1;
        end else begin
          skid_q    <= in_payload;
          skid_full <= 1'b1;
        end
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      in_ready <= !skid_full_next;
    end
  end

endmodule

// File: rtl/axis_demux_1to4.sv
// AXI-stream 1-to-4 demultiplexer with registered output and skid buffer.
// Define AXIS_DEMUX_PKT_EN for last ports and packet-locked routing; otherwise sel routes every beat.
module axis_demux_1to4
  import axis_pkg::*;
#(
  parameter int WIDTH = AXIS_DATA_W,
  parameter int depth = AXIS_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [depth-1:0] sel,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
`ifdef AXIS_DEMUX_PKT_EN
  input  logic             last,
`endif
  output logic             ready,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] data_3,
  output logic             valid_0,
  output logic             valid_1,
  output logic             valid_2,
  output logic             valid_3,
`ifdef AXIS_DEMUX_PKT_EN
  output logic             last_0,
  output logic             last_1,
  output logic             last_2,
  output logic             last_3,
`endif
  input  logic             ready_0,
  input  logic             ready_1,
  input  logic             ready_2,
  input  logic             ready_3
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
`ifdef AXIS_DEMUX_PKT_EN
    logic             last;
`endif
    axis_sel_t        dst;
  } beat_t;

  beat_t                  in_beat;
  beat_t                  out_beat;
  logic                   out_valid;
  logic                   out_ready;
  logic                   accept;
  axis_sel_t              sel_i;
  axis_sel_t              beat_dst;
  logic [AXIS_NPORTS-1:0] ready_vec;
  logic [AXIS_NPORTS-1:0] valid_vec;

  assign sel_i  = sel;
  assign accept = valid && ready;

`ifdef AXIS_DEMUX_PKT_EN
  axis_demux_state_e state, state_next;
  axis_sel_t         dst_lock, dst_lock_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dst_lock <= '0;
    end else begin
      state    <= state_next;
      dst_lock <= dst_lock_next;
    end
  end

  // The first beat of a packet routes on sel directly and captures it for the rest.
  always_comb begin
    state_next    = state;
    dst_lock_next = dst_lock;
    beat_dst      = sel_i;
    case (state)
      IDLE: begin
        if (accept) begin
          dst_lock_next = sel_i;
          if (!last) state_next = BUSY;
        end
      end
      BUSY: begin
        beat_dst = dst_lock;
        if (accept && last) state_next = IDLE;
      end
    endcase
  end
`else
  assign beat_dst = sel_i;
`endif

  always_comb begin
    in_beat      = '0;
    in_beat.data = data;
`ifdef AXIS_DEMUX_PKT_EN
    in_beat.last = last;
`endif
    in_beat.dst  = beat_dst;
  end

  axis_skid_buffer #(
    .W($bits(beat_t))
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_payload (in_beat),
    .in_valid   (valid),
    .in_ready   (ready),
    .out_payload(out_beat),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Only the ready of the port that owns the held beat can consume it.
  assign ready_vec = {ready_3, ready_2, ready_1, ready_0};
  assign out_ready = ready_vec[out_beat.dst];

  always_comb begin
    valid_vec = '0;
    if (out_valid) valid_vec[out_beat.dst] = 1'b1;
  end

  assign data_0  = out_beat.data;
  assign data_1  = out_beat.data;
  assign data_2  = out_beat.data;
  assign data_3  = out_beat.data;
  assign valid_0 = valid_vec[0];
  assign valid_1 = valid_vec[1];
  assign valid_2 = valid_vec[2];
  assign valid_3 = valid_vec[3];
`ifdef AXIS_DEMUX_PKT_EN
  assign last_0  = valid_vec[0] && out_beat.last;
  assign last_1  = valid_vec[1] && out_beat.last;
  assign last_2  = valid_vec[2] && out_beat.last;
  assign last_3  = valid_vec[3] && out_beat.last;
`endif

endmodule

// File: tb/tb_axis_demux_1to4.sv
// Randomized self-checking bench for axis_demux_1to4 against a queue-based reference model.
// Builds with or without AXIS_DEMUX_PKT_EN.
module tb_axis_demux_1to4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  sel = '0;
  logic [15:0] data = '0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        ready;
  logic [15:0] data_0, data_1, data_2, data_3;
  logic        valid_0, valid_1, valid_2, valid_3;
  logic        last_0, last_1, last_2, last_3;
  logic        ready_0 = 1'b1, ready_1 = 1'b1, ready_2 = 1'b1, ready_3 = 1'b1;

  axis_demux_1to4 #(.WIDTH(16), .depth(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .data   (data),
    .valid  (valid),
`ifdef AXIS_DEMUX_PKT_EN
    .last   (last),
`endif
    .ready  (ready),
    .data_0 (data_0),
    .data_1 (data_1),
    .data_2 (data_2),
    .data_3 (data_3),
    .valid_0(valid_0),
    .valid_1(valid_1),
    .valid_2(valid_2),
    .valid_3(valid_3),
`ifdef AXIS_DEMUX_PKT_EN
    .last_0 (last_0),
    .last_1 (last_1),
    .last_2 (last_2),
    .last_3 (last_3),
`endif
    .ready_0(ready_0),
    .ready_1(ready_1),
    .ready_2(ready_2),
    .ready_3(ready_3)
  );

`ifndef AXIS_DEMUX_PKT_EN
  assign last_0 = 1'b0;
  assign last_1 = 1'b0;
  assign last_2 = 1'b0;
  assign last_3 = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int          dst;
    logic [15:0] data;
    logic        lst;
  } ent_t;

  // Reference model: beats in flight, oldest first, plus packet routing state.
  ent_t q[$];
  bit   in_pkt;
  int   lock_dst;
  bit   rdy_known;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int deliv[4] = '{0, 0, 0, 0};
  bit last_acc;
  bit tp_on = 0;
  int tp_first = -1, tp_last = -1, tp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] port_data(input int p);
    case (p)
      0:       return data_0;
      1:       return data_1;
      2:       return data_2;
      default: return data_3;
    endcase
  endfunction

  function automatic logic [3:0] valid_vec();
    return {valid_3, valid_2, valid_1, valid_0};
  endfunction

  // One clock: compare outputs with the model at negedge, then advance the model at posedge.
  task automatic cycle();
    logic [3:0] vv, rv, ev, lv, el;
    bit   acc, cons;
    ent_t e;
    @(negedge clk);
    vv = valid_vec();
    rv = {ready_3, ready_2, ready_1, ready_0};
    lv = {last_3, last_2, last_1, last_0};
    ev = '0;
    el = '0;
    if (q.size() > 0) begin
      ev[q[0].dst] = 1'b1;
`ifdef AXIS_DEMUX_PKT_EN
      el[q[0].dst] = q[0].lst;
`endif
    end
    check("valid", {28'd0, vv}, {28'd0, ev});
    if (q.size() > 0) check("data", {16'd0, port_data(q[0].dst)}, {16'd0, q[0].data});
    check("last", {28'd0, lv}, {28'd0, el});
    if (rdy_known) check("ready", {31'd0, ready}, {31'd0, (q.size() < 2)});
    acc  = valid && ready;
    cons = (vv & rv) != 0;
    e.data = data;
    e.lst  = last;
`ifdef AXIS_DEMUX_PKT_EN
    e.dst = in_pkt ? lock_dst : int'(sel);
`else
    e.dst = int'(sel);
`endif
    @(posedge clk);
    if (cons && q.size() > 0) begin
      deliv[q[0].dst]++;
      if (tp_on && q[0].dst == 0) begin
        if (tp_first < 0) tp_first = cyc;
        tp_last = cyc;
        tp_cnt++;
      end
      void'(q.pop_front());
    end
    if (acc) begin
      q.push_back(e);
      lock_dst = e.dst;
      in_pkt   = !e.lst;
    end
    last_acc  = acc;
    rdy_known = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    valid     = 1'b0;
    q.delete();
    in_pkt    = 1'b0;
    rdy_known = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input int s, input logic [15:0] d, input logic l);
    bit got = 0;
    sel   = 2'(s);
    data  = d;
    last  = l;
    valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      got = last_acc;
    end
    valid = 1'b0;
    check("send_acc", {31'd0, got}, 32'd1);
  endtask

  task automatic drain();
    valid   = 1'b0;
    ready_0 = 1'b1;
    ready_1 = 1'b1;
    ready_2 = 1'b1;
    ready_3 = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) cycle();
    cycle();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int d0[4];
    int acc_cnt;
    int i, budget;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_valid", {28'd0, valid_vec()}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_data0", {16'd0, data_0}, 32'd0);
    do_reset();
    cycle();
    check("rst_ready_rel", {31'd0, ready}, 32'd1);

    // Per-port routing of single-beat packets
    for (int n = 0; n < 4; n++) begin
      d0 = deliv;
      send(n, 16'hA000 + 16'(n), 1'b1);
      check("route_lat", {28'd0, valid_vec()}, 32'd1 << n);
      drain();
      for (int p = 0; p < 4; p++) check("route_cnt", deliv[p] - d0[p], (p == n) ? 1 : 0);
    end

    // Packet lock: sel toggles to 1 after the first beat
    d0 = deliv;
    send(2, 16'h2001, 1'b0);
    send(1, 16'h2002, 1'b0);
    send(1, 16'h2003, 1'b0);
    send(1, 16'h2004, 1'b1);
    send(1, 16'h1001, 1'b1);
    drain();
`ifdef AXIS_DEMUX_PKT_EN
    check("lock_p2", deliv[2] - d0[2], 4);
    check("lock_p1", deliv[1] - d0[1], 1);
`else
    check("beat_p2", deliv[2] - d0[2], 1);
    check("beat_p1", deliv[1] - d0[1], 4);
`endif

    // Backpressure on port 3; other readies are high and must be ignored
    d0 = deliv;
    ready_3 = 1'b0;
    send(3, 16'hB001, 1'b1);
    send(3, 16'hB002, 1'b1);
    check("bp_ready", {31'd0, ready}, 32'd0);
    sel = 2'd3; data = 16'hB003; last = 1'b1; valid = 1'b1;
    acc_cnt = 0;
    repeat (4) begin
      cycle();
      if (last_acc) acc_cnt++;
    end
    check("bp_stall", acc_cnt, 0);
    check("bp_hold", {16'd0, data_3}, 32'h0000B001);
    ready_3 = 1'b1;
    valid   = 1'b0;
    send(3, 16'hB003, 1'b1);
    drain();
    check("bp_cnt", deliv[3] - d0[3], 3);

    // Throughput: 100 back-to-back beats to port 0
    tp_on = 1;
    sel = 2'd0; last = 1'b1; valid = 1'b1;
    i = 0;
    budget = 0;
    while (i < 100 && budget < 200) begin
      data = 16'hC000 + 16'(i);
      cycle();
      budget++;
      if (last_acc) i++;
    end
    valid = 1'b0;
    drain();
    tp_on = 0;
    check("tp_in_cycles", budget, 100);
    check("tp_count", tp_cnt, 100);
    check("tp_span", tp_last - tp_first, 99);

    // Reset mid-run with two beats held (and a packet open)
    d0 = deliv;
    ready_1 = 1'b0;
    send(1, 16'hD001, 1'b0);
    send(1, 16'hD002, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("rstmid_valid", {28'd0, valid_vec()}, 32'd0);
    check("rstmid_ready", {31'd0, ready}, 32'd0);
    do_reset();
    ready_1 = 1'b1;
    repeat (3) cycle();
    send(0, 16'hD003, 1'b1);
    drain();
    check("rstmid_p0", deliv[0] - d0[0], 1);
    check("rstmid_p1", deliv[1] - d0[1], 0);

    // Randomized traffic with random downstream backpressure
    for (int k = 0; k < 3000; k++) begin
      valid   = ($urandom_range(0, 3) != 0);
      sel     = 2'($urandom_range(0, 3));
      last    = ($urandom_range(0, 2) == 0);
      data    = 16'($urandom);
      ready_0 = ($urandom_range(0, 9) < 7);
      ready_1 = ($urandom_range(0, 9) < 7);
      ready_2 = ($urandom_range(0, 9) < 7);
      ready_3 = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_demux_1to4.md
Name: axis_demux_1to4

Overview:
AXI-stream style 1-to-4 demultiplexer. It routes one upstream valid/ready stream to one of four downstream ports, selected by sel. Routing is packet-aware: sel is latched on the first beat of a packet and held until the beat carrying last is accepted. A registered output stage with a skid buffer gives 1-cycle latency at full throughput, with a registered upstream ready.

Parameters:
WIDTH, 16, data width of every data port in bits
depth, 2, sel width; fixed at 2 for four outputs

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
sel  input  depth  destination select, sampled on first beat of a packet
data  input  WIDTH  upstream data
valid  input  1  upstream valid
last  input  1  upstream end-of-packet (present only with AXIS_DEMUX_PKT_EN)
ready  output  1  upstream ready, registered
data_0..data_3  output  WIDTH  downstream data, all driven from the same output register
valid_0..valid_3  output  1  downstream valid, at most one high at a time
last_0..last_3  output  1  downstream last, qualified by valid_n (only with AXIS_DEMUX_PKT_EN)
ready_0..ready_3  input  1  downstream ready

Behaviour:
- Reset (async assert, sync deassert): ready=0 during rst, ready=1 on the first clk after release. All valid_n=0, data_n=0, last_n=0. Skid buffer empty. State IDLE.
- Upstream transfer: valid&&ready on a rising edge. Downstream transfer on port n: valid_n&&ready_n.
- Output register holds {data, last, dst}. valid_n = out_valid && (dst==n). The selected ready_n is the only ready that matters; unselected ready_n are ignored.
- Latency: a beat accepted at edge k is visible on the outputs after edge k (one register stage).
- Skid buffer: one entry. The output register loads when it is empty or its beat is being consumed this cycle. Otherwise an incoming beat goes to the skid buffer.
- ready = !skid_full, registered. With the skid buffer full, ready=0 until the output beat is consumed. The skid entry then moves to the output register and ready returns to 1 on the next cycle.
- Throughput: 1 beat/cycle sustained while the selected ready_n=1.
- Order preserved; no beat is dropped or duplicated.
- FSM (packet lock):
  - IDLE: on an accepted beat, dst_lock <= sel. If last=1, stay IDLE (single-beat packet); else go to BUSY.
  - BUSY: every accepted beat uses dst_lock and sel is ignored. An accepted beat with last=1 returns to IDLE.
- sel changing mid-packet has no effect. A new sel takes effect only on the first beat after last.
- Simultaneous downstream consume and upstream accept with the skid buffer empty: the output register reloads directly, with no bubble.
- Downstream holds ready_n=0 indefinitely: at most 2 beats are held (output register + skid); upstream is stalled.
- Output stability: while valid_n=1 and ready_n=0, data_n/last_n/valid_n stay stable.
- Reset mid-packet: all held beats are discarded and the FSM returns to IDLE. The next beat is treated as a packet start.

Optional Feature:
AXIS_DEMUX_PKT_EN
- Defined: last/last_n ports exist and the packet-lock FSM is active as above.
- Undefined: no last ports and no FSM. sel is sampled with every accepted beat, i.e. per-beat routing with the same latency and skid behaviour.

Decomposition:
- Package axis_pkg:
  - constant AXIS_NPORTS=4
  - typedef for the sel index
  - enum axis_demux_state_e {IDLE, BUSY}
  - struct axis_beat_t {data, last, dst}
- Sub-module axis_skid_buffer: parameterized on the beat payload width. It owns the output register, the skid register and the registered ready. The top level owns the FSM, dst lock and the one-hot valid decode.

Test Plan:
1. Reset: assert rst mid-run with 2 beats held -> all valid_n=0 immediately; after release, ready=1 and no stale beat appears.
2. Per-port routing: sel=0..3, single-beat packets data=16'hA000+n, all ready_n=1 -> each beat appears only on port n, one cycle after acceptance; the other valid_m stay 0.
3. Packet lock: 4-beat packet with sel=2, sel toggled to 1 on beat 2 -> all 4 beats on port 2, last_2 on beat 4. The next packet with sel=1 goes to port 1.
4. Backpressure: sel=3, ready_3=0 while 3 beats are offered -> 2 beats held, ready=0 after the second. Raise ready_3 -> beats exit in order 1,2,3 with no loss or duplication.
5. Throughput: 100 back-to-back beats to port 0 with ready_0=1 -> 100 transfers in 100 consecutive cycles after the first-beat latency.
6. Random ready_n and valid stimulus with a scoreboard, built both with and without AXIS_DEMUX_PKT_EN -> exact in-order delivery per destination, and routing matches the latched or per-beat rule.
